// File: rtl/bcd_display_converter_pkg.sv
// Shared definitions for the binary-to-BCD display converter.
//   - state_t        : FSM state encoding (IDLE/LOAD/SHIFT/DONE)
//   - BCD_ADJ_THRESH : digit value at or above which double-dabble adds 3
//   - BCD_ADJ_ADD    : correction added to a digit before each shift
//   - bcd_adjust()   : single-digit double-dabble correction
package bcd_display_converter_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
    localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

    // A digit of 5..9 would overflow past 9 when doubled; pre-adding 3
    // makes the carry land in the next digit after the shift.
    function automatic logic [3:0] bcd_adjust(input logic [3:0] digit);
        logic [3:0] result;
        if (digit >= BCD_ADJ_THRESH) begin
            result = digit + BCD_ADJ_ADD;
        end else begin
            result = digit;
        end
        return result;
    endfunction

endpackage

// File: rtl/bcd_display_converter_add3_digit.sv
// One BCD digit of the double-dabble correction stage (purely combinational).
// Ports:
//   digit_in  [3:0] : current scratch digit
//   digit_out [3:0] : digit_in + 3 when digit_in >= 5, otherwise digit_in
module bcd_add3_digit
    import bcd_display_converter_pkg::*;
(
    input  logic [3:0] digit_in,
    output logic [3:0] digit_out
);

    // Correction applied before the shift
    always_comb begin
        digit_out = bcd_adjust(digit_in);
    end

endmodule

// File: rtl/bcd_display_converter.sv
// Iterative binary-to-BCD converter for the seven-segment display path.
// Converts one input bit per clock (double-dabble) and holds the last
// result on bcd_out/neg until a new conversion completes.
// Ports:
//   ssdclk      : display-domain clock, rising edge
//   rst         : asynchronous active-low reset
//   start       : conversion request, honoured only when idle
//   bin_in      : value to convert
//   signed_mode : 1 = bin_in is two's complement
//   bcd_out     : packed BCD result, digit 0 in [3:0]
//   neg         : result is negative
//   busy        : conversion in progress (LOAD and SHIFT)
//   valid       : one-cycle pulse when bcd_out/neg update
module bcd_display_converter
    import bcd_display_converter_pkg::*;
#(
    parameter int IN_WIDTH  = 13,
    parameter int DIGITS    = 4,
    parameter int AUTO_MODE = 1
) (
    input  logic                  ssdclk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [IN_WIDTH-1:0]   bin_in,
    input  logic                  signed_mode,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  neg,
    output logic                  busy,
    output logic                  valid
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(IN_WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(IN_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_STEP = CNT_W'(1);
    localparam logic [IN_WIDTH-1:0] ONE_IN = IN_WIDTH'(1);
    localparam logic AUTO_EN = (AUTO_MODE != 0);

    state_t                    state_r;
    state_t                    next_state_s;
    logic [CNT_W-1:0]          cnt_r;
    logic [IN_WIDTH-1:0]       last_in_r;
    logic                      last_mode_r;
    logic [IN_WIDTH-1:0]       mag_r;
    logic [BCD_W-1:0]          scratch_r;
    logic                      pending_neg_r;
    logic [BCD_W-1:0]          bcd_out_r;
    logic                      neg_r;
    logic                      busy_r;
    logic                      valid_r;

    logic [BCD_W-1:0]          adj_s;
    logic [BCD_W+IN_WIDTH-1:0] shift_s;
    logic                      trigger_s;
    logic                      load_neg_s;
    logic [IN_WIDTH-1:0]       load_mag_s;

    assign bcd_out = bcd_out_r;
    assign neg     = neg_r;
    assign busy    = busy_r;
    assign valid   = valid_r;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_add3_digit u_add3 (
            .digit_in  (scratch_r[4*g +: 4]),
            .digit_out (adj_s[4*g +: 4])
        );
    end

    // Conversion trigger, sign/magnitude split and the shift step
    always_comb begin
        trigger_s  = start | (AUTO_EN & ((bin_in != last_in_r) |
                                         (signed_mode != last_mode_r)));
        // The most negative input negates to 2^(IN_WIDTH-1), which still
        // fits as an unsigned magnitude, so no overflow handling is needed.
        load_neg_s = last_mode_r & last_in_r[IN_WIDTH-1];
        if (load_neg_s) begin
            load_mag_s = ~last_in_r + ONE_IN;
        end else begin
            load_mag_s = last_in_r;
        end
        shift_s = {adj_s, mag_r} << 1;
    end

    // Next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (trigger_s) begin
                    next_state_s = S_LOAD;
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_LOAD: next_state_s = S_SHIFT;
            S_SHIFT: begin
                if (cnt_r == CNT_LAST) begin
                    next_state_s = S_DONE;
                end else begin
                    next_state_s = S_SHIFT;
                end
            end
            S_DONE:  next_state_s = S_IDLE;
            default: next_state_s = S_IDLE;
        endcase
    end

    // State register plus registered busy/valid strobes
    always_ff @(posedge ssdclk or negedge rst) begin
        if (!rst) begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            state_r <= next_state_s;
            busy_r  <= (next_state_s == S_LOAD) || (next_state_s == S_SHIFT);
            valid_r <= (state_r == S_DONE);
        end
    end

    // Datapath: input capture, double-dabble iteration, result hold
    always_ff @(posedge ssdclk or negedge rst) begin
        if (!rst) begin
            cnt_r         <= '0;
            last_in_r     <= '0;
            last_mode_r   <= 1'b0;
            mag_r         <= '0;
            scratch_r     <= '0;
            pending_neg_r <= 1'b0;
            bcd_out_r     <= '0;
            neg_r         <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (trigger_s) begin
                        last_in_r   <= bin_in;
                        last_mode_r <= signed_mode;
                    end
                end
                S_LOAD: begin
                    mag_r         <= load_mag_s;
                    pending_neg_r <= load_neg_s;
                    scratch_r     <= '0;
                    cnt_r         <= CNT_INIT;
                end
                S_SHIFT: begin
                    scratch_r <= shift_s[BCD_W+IN_WIDTH-1:IN_WIDTH];
                    mag_r     <= shift_s[IN_WIDTH-1:0];
                    cnt_r     <= cnt_r - CNT_STEP;
                end
                S_DONE: begin
                    bcd_out_r <= scratch_r;
                    neg_r     <= pending_neg_r;
                end
                default: begin
                    cnt_r <= '0;
                end
            endcase
        end
    end

endmodule
